mulacc_multi_cfu: RTL and testbench

//  Pipelined multiply-accumulate CFU with CFU_STATES independent accumulators.

---
 rtl/mulacc_multi_cfu.sv | 242 ++++++++++++++++++++++++
 tb/tb_mulacc_multi_cfu.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mulacc_multi_cfu.sv
// Pipelined multiply-accumulate CFU with CFU_STATES independent accumulators,
// valid/ready backpressure, and error responses for bad function or state ids.
module mulacc_multi_cfu #(
    parameter int CFU_FUNCTION_ID_W = 3,
    parameter int CFU_REQ_RESP_ID_W = 6,
    parameter int CFU_STATE_ID_W    = 2,
    parameter int CFU_STATES        = 4,
    parameter int CFU_REQ_DATA_W    = 32,
    parameter int CFU_RESP_DATA_W   = 32,
    parameter int CFU_ERROR_ID_W    = 32,
    parameter int CFU_LATENCY       = 3,
    parameter int CFU_SIGNED        = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [CFU_FUNCTION_ID_W-1:0]  req_function_id,
    input  logic [CFU_STATE_ID_W-1:0]     req_state_id,
    input  logic [CFU_REQ_RESP_ID_W-1:0]  req_id,
    input  logic [CFU_REQ_DATA_W-1:0]     req_data0,
    input  logic [CFU_REQ_DATA_W-1:0]     req_data1,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [CFU_REQ_RESP_ID_W-1:0]  resp_id,
    output logic [CFU_RESP_DATA_W-1:0]    resp_data,
    output logic                          resp_ok,
    output logic [CFU_ERROR_ID_W-1:0]     resp_error_id
);
    localparam int W    = CFU_REQ_DATA_W;
    localparam int NSTG = CFU_LATENCY - 1;
    localparam int LAST = NSTG - 1;

    typedef enum logic [2:0] {
        OP_CLEAR  = 3'd0,
        OP_MULACC = 3'd1,
        OP_MULSUB = 3'd2,
        OP_READ   = 3'd3,
        OP_LOAD   = 3'd4
    } op_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FUNC  = 2'd1;
    localparam logic [1:0] ERR_STATE = 2'd2;
    localparam logic [CFU_FUNCTION_ID_W-1:0] FID_MAX = CFU_FUNCTION_ID_W'(4);
    localparam logic [CFU_STATE_ID_W:0] STATE_LIMIT = (CFU_STATE_ID_W + 1)'(CFU_STATES);

    logic advance;
    logic accept;

    assign advance   = !resp_valid || resp_ready;
    assign req_ready = advance;
    assign accept    = req_valid && advance;

    // Only the low W bits of the product are kept; sign extension is what
    // distinguishes the two modes on the full-width product.
    logic [W-1:0] prod_w;
    if (CFU_SIGNED != 0) begin : g_signed
        assign prod_w = W'({{W{req_data0[W-1]}}, req_data0} * {{W{req_data1[W-1]}}, req_data1});
    end else begin : g_unsigned
        assign prod_w = W'({{W{1'b0}}, req_data0} * {{W{1'b0}}, req_data1});
    end

    op_e        dec_op;
    logic [1:0] dec_err;

    always_comb begin
        case (req_function_id[2:0])
            3'd0:    dec_op = OP_CLEAR;
            3'd1:    dec_op = OP_MULACC;
            3'd2:    dec_op = OP_MULSUB;
            3'd4:    dec_op = OP_LOAD;
            default: dec_op = OP_READ;
        endcase
        if (req_function_id > FID_MAX) begin
            dec_err = ERR_FUNC;
        end else if ({1'b0, req_state_id} >= STATE_LIMIT) begin
            dec_err = ERR_STATE;
        end else begin
            dec_err = ERR_NONE;
        end
    end

    logic                         stg_valid_q [NSTG];
    logic                         stg_valid_d [NSTG];
    op_e                          stg_op_q    [NSTG];
    op_e                          stg_op_d    [NSTG];
    logic [1:0]                   stg_err_q   [NSTG];
    logic [1:0]                   stg_err_d   [NSTG];
    logic [CFU_STATE_ID_W-1:0]    stg_state_q [NSTG];
    logic [CFU_STATE_ID_W-1:0]    stg_state_d [NSTG];
    logic [CFU_REQ_RESP_ID_W-1:0] stg_id_q    [NSTG];
    logic [CFU_REQ_RESP_ID_W-1:0] stg_id_d    [NSTG];
    logic [W-1:0]                 stg_a_q     [NSTG];
    logic [W-1:0]                 stg_a_d     [NSTG];
    logic [W-1:0]                 stg_prod_q  [NSTG];
    logic [W-1:0]                 stg_prod_d  [NSTG];

    always_comb begin
        for (int i = 0; i < NSTG; i++) begin
            stg_valid_d[i] = stg_valid_q[i];
            stg_op_d[i]    = stg_op_q[i];
            stg_err_d[i]   = stg_err_q[i];
            stg_state_d[i] = stg_state_q[i];
            stg_id_d[i]    = stg_id_q[i];
            stg_a_d[i]     = stg_a_q[i];
            stg_prod_d[i]  = stg_prod_q[i];
        end
        if (advance) begin
            stg_valid_d[0] = accept;
            stg_op_d[0]    = dec_op;
            stg_err_d[0]   = dec_err;
            stg_state_d[0] = req_state_id;
            stg_id_d[0]    = req_id;
            stg_a_d[0]     = req_data0;
            stg_prod_d[0]  = prod_w;
            for (int i = 1; i < NSTG; i++) begin
                stg_valid_d[i] = stg_valid_q[i-1];
                stg_op_d[i]    = stg_op_q[i-1];
                stg_err_d[i]   = stg_err_q[i-1];
                stg_state_d[i] = stg_state_q[i-1];
                stg_id_d[i]    = stg_id_q[i-1];
                stg_a_d[i]     = stg_a_q[i-1];
                stg_prod_d[i]  = stg_prod_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSTG; i++) begin
                stg_valid_q[i] <= 1'b0;
                stg_op_q[i]    <= OP_READ;
                stg_err_q[i]   <= ERR_NONE;
                stg_state_q[i] <= '0;
                stg_id_q[i]    <= '0;
                stg_a_q[i]     <= '0;
                stg_prod_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NSTG; i++) begin
                stg_valid_q[i] <= stg_valid_d[i];
                stg_op_q[i]    <= stg_op_d[i];
                stg_err_q[i]   <= stg_err_d[i];
                stg_state_q[i] <= stg_state_d[i];
                stg_id_q[i]    <= stg_id_d[i];
                stg_a_q[i]     <= stg_a_d[i];
                stg_prod_q[i]  <= stg_prod_d[i];
            end
        end
    end

    logic [W-1:0] acc_vec [CFU_STATES];
    logic [W-1:0] acc_cur;
    logic [W-1:0] acc_new;
    logic         commit;

    // The accumulator write and the response load share one edge, so the
    // next op on the same accumulator always reads the committed value.
    for (genvar gi = 0; gi < CFU_STATES; gi++) begin : g_acc
        logic [W-1:0] acc_q;
        logic [W-1:0] acc_d;

        always_comb begin
            acc_d = acc_q;
            if (commit && (stg_state_q[LAST] == CFU_STATE_ID_W'(gi))) begin
                acc_d = acc_new;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end

        assign acc_vec[gi] = acc_q;
    end

    logic                         resp_valid_q, resp_valid_d;
    logic [CFU_REQ_RESP_ID_W-1:0] resp_id_q, resp_id_d;
    logic [CFU_RESP_DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                         resp_ok_q, resp_ok_d;
    logic [CFU_ERROR_ID_W-1:0]    resp_error_id_q, resp_error_id_d;

    always_comb begin
        acc_cur = '0;
        for (int i = 0; i < CFU_STATES; i++) begin
            if (stg_state_q[LAST] == CFU_STATE_ID_W'(i)) begin
                acc_cur = acc_vec[i];
            end
        end
        case (stg_op_q[LAST])
            OP_CLEAR:  acc_new = '0;
            OP_MULACC: acc_new = acc_cur + stg_prod_q[LAST];
            OP_MULSUB: acc_new = acc_cur - stg_prod_q[LAST];
            OP_LOAD:   acc_new = stg_a_q[LAST];
            default:   acc_new = acc_cur;
        endcase
        commit = advance && stg_valid_q[LAST] && (stg_err_q[LAST] == ERR_NONE);

        resp_valid_d    = resp_valid_q;
        resp_id_d       = resp_id_q;
        resp_data_d     = resp_data_q;
        resp_ok_d       = resp_ok_q;
        resp_error_id_d = resp_error_id_q;
        if (advance) begin
            resp_valid_d = stg_valid_q[LAST];
            if (stg_valid_q[LAST]) begin
                resp_id_d       = stg_id_q[LAST];
                resp_ok_d       = (stg_err_q[LAST] == ERR_NONE);
                resp_data_d     = (stg_err_q[LAST] == ERR_NONE) ? acc_new : '0;
                resp_error_id_d = CFU_ERROR_ID_W'(stg_err_q[LAST]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_data_q     <= '0;
            resp_ok_q       <= 1'b0;
            resp_error_id_q <= '0;
        end else begin
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_data_q     <= resp_data_d;
            resp_ok_q       <= resp_ok_d;
            resp_error_id_q <= resp_error_id_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_data     = resp_data_q;
    assign resp_ok       = resp_ok_q;
    assign resp_error_id = resp_error_id_q;

endmodule

// File: tb/tb_mulacc_multi_cfu.sv
// Directed + randomized bench for mulacc_multi_cfu; responses are scored
// against an in-order queue filled from a plain-arithmetic accumulator model.
`timescale 1ns/1ps
module tb_mulacc_multi_cfu;
    localparam int NS  = 3;
    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_function_id = '0;
    logic [1:0]  req_state_id = '0;
    logic [5:0]  req_id = '0;
    logic [31:0] req_data0 = '0;
    logic [31:0] req_data1 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [5:0]  resp_id;
    logic [31:0] resp_data;
    logic        resp_ok;
    logic [31:0] resp_error_id;

    mulacc_multi_cfu #(
        .CFU_STATES (NS),
        .CFU_SIGNED (1),
        .CFU_LATENCY(LAT)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_function_id(req_function_id),
        .req_state_id   (req_state_id),
        .req_id         (req_id),
        .req_data0      (req_data0),
        .req_data1      (req_data1),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_data      (resp_data),
        .resp_ok        (resp_ok),
        .resp_error_id  (resp_error_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  id;
        logic [31:0] data;
        logic        ok;
        logic [31:0] err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_rsp;
    logic [31:0] macc [NS];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          chk_lat = 0;
    bit          rand_rr = 0;
    bit          accepted = 0;
    bit          held = 0;
    int          stall_left = 0;
    logic [5:0]  next_id = '0;
    logic [5:0]  h_id;
    logic [31:0] h_data;
    logic [31:0] h_err;
    logic        h_ok;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // Reference: accumulator semantics straight from the function table.
    function automatic exp_t model(input int f, input int s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.id  = '0;
        e.cyc = 0;
        if (f > 4) begin
            e.data = 0; e.ok = 0; e.err = 1;
        end else if (s >= NS) begin
            e.data = 0; e.ok = 0; e.err = 2;
        end else begin
            case (f)
                0: macc[s] = 32'd0;
                1: macc[s] = macc[s] + a * b;
                2: macc[s] = macc[s] - a * b;
                4: macc[s] = a;
                default: ;
            endcase
            e.data = macc[s]; e.ok = 1; e.err = 0;
        end
        return e;
    endfunction

    task automatic tick();
        exp_t e;
        if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);
        else resp_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        @(negedge clock);
        accepted = 0;
        if (held) begin
            chk("hold_valid", 64'(resp_valid), 64'(1));
            chk("hold_id", 64'(resp_id), 64'(h_id));
            chk("hold_data", 64'(resp_data), 64'(h_data));
            chk("hold_ok", 64'(resp_ok), 64'(h_ok));
            chk("hold_err", 64'(resp_error_id), 64'(h_err));
        end
        chk("req_ready", 64'(req_ready), 64'(!resp_valid || resp_ready));
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_resp", 64'(resp_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("resp_id", 64'(resp_id), 64'(e.id));
                chk("resp_data", 64'(resp_data), 64'(e.data));
                chk("resp_ok", 64'(resp_ok), 64'(e.ok));
                chk("resp_err", 64'(resp_error_id), 64'(e.err));
                if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'(LAT));
                last_rsp.id = resp_id; last_rsp.data = resp_data;
                last_rsp.ok = resp_ok; last_rsp.err = resp_error_id;
            end
        end
        held = resp_valid && !resp_ready;
        h_id = resp_id; h_data = resp_data; h_ok = resp_ok; h_err = resp_error_id;
        if (req_valid && req_ready) begin
            e = model(int'(req_function_id), int'(req_state_id), req_data0, req_data1);
            e.id  = req_id;
            e.cyc = cyc;
            exp_q.push_back(e);
            accepted = 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int f, input int s, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_function_id = 3'(f);
        req_state_id = 2'(s);
        req_id = next_id;
        req_data0 = a;
        req_data1 = b;
        next_id++;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (accepted) break;
        end
        chk("req_accepted", 64'(accepted), 64'(1));
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_idle(input string tag);
        @(negedge clock);
        chk({tag, "_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, "_id"}, 64'(resp_id), 64'(0));
        chk({tag, "_data"}, 64'(resp_data), 64'(0));
        chk({tag, "_ok"}, 64'(resp_ok), 64'(0));
        chk({tag, "_err"}, 64'(resp_error_id), 64'(0));
        chk({tag, "_ready"}, 64'(req_ready), 64'(1));
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        exp_q.delete();
        held = 0;
        for (int i = 0; i < NS; i++) macc[i] = 32'd0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            chk("in_reset_valid", 64'(resp_valid), 64'(0));
            @(posedge clock);
        end
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();
        check_idle("reset");

        // 1: running sum 1..100 on state 0, back-to-back, fixed latency
        chk_lat = 1;
        for (int b = 1; b <= 100; b++) send(1, 0, 32'd1, 32'(b));
        drain();
        chk_lat = 0;
        chk("t1_sum", 64'(last_rsp.data), 64'd5050);
        $display("txn t1 sum=%0d", last_rsp.data);

        // 2: interleaved accumulators
        send(0, 0, 32'd0, 32'd0);
        send(0, 2, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(1, 0, 32'd2, 32'd3);
            send(1, 2, 32'd5, 32'd7);
        end
        send(3, 0, 32'd0, 32'd0);
        drain();
        chk("t2_read0", 64'(last_rsp.data), 64'd24);
        send(3, 2, 32'd0, 32'd0);
        drain();
        chk("t2_read2", 64'(last_rsp.data), 64'd140);
        $display("txn t2 acc2=%0d", last_rsp.data);

        // 3: five-cycle response stall in the middle of ten requests
        for (int i = 0; i < 10; i++) begin
            if (i == 4) stall_left = 5;
            send(1, 1, $urandom, $urandom);
        end
        drain();
        send(3, 1, 32'd0, 32'd0);
        drain();
        chk("t3_final", 64'(last_rsp.data), 64'(macc[1]));
        $display("txn t3 acc1=%08h", last_rsp.data);

        // 4: error responses leave accumulators untouched
        send(7, 0, 32'd9, 32'd9);
        drain();
        chk("t4_badfn_err", 64'(last_rsp.err), 64'd1);
        send(1, 3, 32'd5, 32'd5);
        drain();
        chk("t4_badst_err", 64'(last_rsp.err), 64'd2);
        chk("t4_badst_ok", 64'(last_rsp.ok), 64'd0);
        send(7, 3, 32'd1, 32'd1);
        drain();
        chk("t4_prio_err", 64'(last_rsp.err), 64'd1);
        send(3, 0, 32'd0, 32'd0);
        drain();
        chk("t4_unchanged", 64'(last_rsp.data), 64'd24);
        $display("txn t4 acc0=%0d", last_rsp.data);

        // 5: signed load/mulsub/mulacc with wraparound
        send(4, 1, 32'd10, 32'd0);
        send(2, 1, -32'sd3, 32'd4);
        drain();
        chk("t5_mulsub", 64'(last_rsp.data), 64'd22);
        send(1, 1, 32'h7FFF_FFFF, 32'd2);
        drain();
        chk("t5_wrap", 64'(last_rsp.data), 64'h14);
        $display("txn t5 acc1=%08h", last_rsp.data);

        // randomized mix with random backpressure
        rand_rr = 1;
        for (int i = 0; i < 150; i++) begin
            send($urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom);
            if ($urandom_range(0, 4) == 0) begin
                req_valid = 1'b0;
                tick();
            end
        end
        drain();
        rand_rr = 0;
        for (int s = 0; s < NS; s++) begin
            send(3, s, 32'd0, 32'd0);
            drain();
            $display("txn rand acc%0d=%08h", s, last_rsp.data);
        end

        // 6: reset with two requests in flight
        send(4, 0, 32'h1234, 32'd0);
        send(1, 0, 32'd3, 32'd3);
        apply_reset();
        check_idle("midrst");
        for (int n = 0; n < 5; n++) begin
            req_valid = 1'b0;
            tick();
        end
        send(3, 0, 32'd0, 32'd0);
        drain();
        chk("t6_read", 64'(last_rsp.data), 64'd0);
        $display("txn t6 acc0=%0d", last_rsp.data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
